// File: rtl/display_timings_600p.sv
// 800x600@60 timing generator: coordinates, syncs, data enable and frame/line strobes.
// Define DISPLAY_TIMINGS_600P_TPG_EN to add an 8-bar colour test pattern on tpg_r/g/b.
module display_timings_600p #(
    parameter int unsigned CORDW  = 11,
    parameter int unsigned H_RES  = 800,
    parameter int unsigned H_FP   = 40,
    parameter int unsigned H_SYNC = 128,
    parameter int unsigned H_BP   = 88,
    parameter int unsigned V_RES  = 600,
    parameter int unsigned V_FP   = 1,
    parameter int unsigned V_SYNC = 4,
    parameter int unsigned V_BP   = 23,
    parameter bit          H_POL  = 1'b1,
    parameter bit          V_POL  = 1'b1
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic             line
`ifdef DISPLAY_TIMINGS_600P_TPG_EN
    ,
    output logic [7:0]       tpg_r,
    output logic [7:0]       tpg_g,
    output logic [7:0]       tpg_b
`endif
);

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CORDW)) begin : g_bad_h
        $error("H_TOTAL-1 does not fit in CORDW bits");
    end
    if ((longint'(V_TOTAL) - 1) >= (longint'(1) << CORDW)) begin : g_bad_v
        $error("V_TOTAL-1 does not fit in CORDW bits");
    end

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] HA_END = CORDW'(H_RES);
    localparam logic [CORDW-1:0] HS_STA = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VA_END = CORDW'(V_RES);
    localparam logic [CORDW-1:0] VS_STA = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

    logic [CORDW-1:0] sx_d, sy_d;
    logic             hsync_d, vsync_d, de_d, frame_d, line_d;

    // Outputs are decoded from next-state counters so they line up with sx/sy.
    always_comb begin
        sx_d = sx + CORDW'(1);
        sy_d = sy;
        if (sx == H_LAST) begin
            sx_d = '0;
            sy_d = (sy == V_LAST) ? '0 : sy + CORDW'(1);
        end
        de_d    = (sx_d < HA_END) && (sy_d < VA_END);
        hsync_d = ((sx_d >= HS_STA) && (sx_d < HS_END)) ? H_POL : ~H_POL;
        vsync_d = ((sy_d >= VS_STA) && (sy_d < VS_END)) ? V_POL : ~V_POL;
        line_d  = (sx_d == '0);
        frame_d = line_d && (sy_d == '0);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx    <= H_LAST;
            sy    <= V_LAST;
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            de    <= 1'b0;
            frame <= 1'b0;
            line  <= 1'b0;
        end else begin
            sx    <= sx_d;
            sy    <= sy_d;
            hsync <= hsync_d;
            vsync <= vsync_d;
            de    <= de_d;
            frame <= frame_d;
            line  <= line_d;
        end
    end

`ifdef DISPLAY_TIMINGS_600P_TPG_EN
    localparam logic [CORDW-1:0] BAR_LAST = CORDW'(H_RES / 8 - 1);

    logic [CORDW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]       bar_idx_q, bar_idx_d;

    // bar_pix/bar_idx track the position of sx within the current bar; reloaded each line.
    always_comb begin
        bar_pix_d = bar_pix_q + CORDW'(1);
        bar_idx_d = bar_idx_q;
        if (line_d) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else if (bar_pix_q == BAR_LAST) begin
            bar_pix_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end
    end

    // Bar order white..black maps to r=~idx[1], g=~idx[2], b=~idx[0].
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            tpg_r     <= 8'h00;
            tpg_g     <= 8'h00;
            tpg_b     <= 8'h00;
        end else begin
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            tpg_r     <= de_d ? {8{~bar_idx_d[1]}} : 8'h00;
            tpg_g     <= de_d ? {8{~bar_idx_d[2]}} : 8'h00;
            tpg_b     <= de_d ? {8{~bar_idx_d[0]}} : 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_display_timings_600p.sv
// Bench for display_timings_600p: default 800x600 instance plus a small negative-polarity
// instance so whole frames fit in a short run.
module tb_display_timings_600p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [10:0] sx, sy, ssx, ssy;
    logic        hs, vs, de, fr, ln;
    logic        shs, svs, sde, sfr, sln;
`ifdef DISPLAY_TIMINGS_600P_TPG_EN
    logic [7:0]  tr, tg, tb_b, sr, sg, sb;
`endif

    display_timings_600p u_dut (
        .clk_pix (clk),
        .rst_pix (rst),
        .sx      (sx),
        .sy      (sy),
        .hsync   (hs),
        .vsync   (vs),
        .de      (de),
        .frame   (fr),
        .line    (ln)
`ifdef DISPLAY_TIMINGS_600P_TPG_EN
        ,
        .tpg_r   (tr),
        .tpg_g   (tg),
        .tpg_b   (tb_b)
`endif
    );

    // 25x13 total, 16x8 active, sync 18..21 / 9..10, both syncs active-low.
    display_timings_600p #(
        .CORDW  (11),
        .H_RES  (16),
        .H_FP   (2),
        .H_SYNC (4),
        .H_BP   (3),
        .V_RES  (8),
        .V_FP   (1),
        .V_SYNC (2),
        .V_BP   (2),
        .H_POL  (1'b0),
        .V_POL  (1'b0)
    ) u_small (
        .clk_pix (clk),
        .rst_pix (rst),
        .sx      (ssx),
        .sy      (ssy),
        .hsync   (shs),
        .vsync   (svs),
        .de      (sde),
        .frame   (sfr),
        .line    (sln)
`ifdef DISPLAY_TIMINGS_600P_TPG_EN
        ,
        .tpg_r   (sr),
        .tpg_g   (sg),
        .tpg_b   (sb)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] decode(input int x, input int y, input int hres,
                                           input int hs0, input int hs1, input int vres,
                                           input int vs0, input int vs1, input bit hp,
                                           input bit vp);
        logic h, v, d;
        h = ((x >= hs0) && (x < hs1)) ? hp : ~hp;
        v = ((y >= vs0) && (y < vs1)) ? vp : ~vp;
        d = (x < hres) && (y < vres);
        return {11'(x), 11'(y), h, v, d, (x == 0) && (y == 0), x == 0};
    endfunction

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    int mx, my, qx, qy;
    int cyc = 0;
    int last_fr = -1;
    int s_vcnt = 0, s_decnt = 0;
    int rise_x = -1, fall_x = -1, de_cnt0 = 0, ln_cnt0 = 0;
    logic prev_hs = 1'b0;

    // One clock: rst as seen by the edge just gone drives the model, then rst is updated.
    task automatic tick(input logic next_rst);
        logic [26:0] em, es;
        logic        r;
        @(negedge clk);
        cyc++;
        r = rst;
        if (r) begin
            mx = 1055; my = 627; qx = 24; qy = 12;
            em = {11'd1055, 11'd627, 5'b00000};
            es = {11'd24, 11'd12, 5'b11000};
            last_fr = -1;
        end else begin
            if (mx == 1055) begin mx = 0; my = (my == 627) ? 0 : my + 1; end
            else mx++;
            if (qx == 24) begin qx = 0; qy = (qy == 12) ? 0 : qy + 1; end
            else qx++;
            em = decode(mx, my, 800, 840, 968, 600, 601, 605, 1'b1, 1'b1);
            es = decode(qx, qy, 16, 18, 22, 8, 9, 11, 1'b0, 1'b0);
        end
        check_eq("main_state", {sx, sy, hs, vs, de, fr, ln}, em);
        check_eq("small_state", {ssx, ssy, shs, svs, sde, sfr, sln}, es);
`ifdef DISPLAY_TIMINGS_600P_TPG_EN
        check_eq("main_tpg", {tr, tg, tb_b}, em[2] ? bar_rgb(mx / 100) : 24'h0);
        check_eq("small_tpg", {sr, sg, sb}, es[2] ? bar_rgb(qx / 2) : 24'h0);
        if (!r && my == 0 && mx == 0)   check_eq("tpg_x0", {tr, tg, tb_b}, 24'hFFFFFF);
        if (!r && my == 0 && mx == 100) check_eq("tpg_x100", {tr, tg, tb_b}, 24'hFFFF00);
        if (!r && my == 0 && mx == 799) check_eq("tpg_x799", {tr, tg, tb_b}, 24'h000000);
        if (!r && my == 0 && mx == 800) check_eq("tpg_x800", {tr, tg, tb_b}, 24'h000000);
        if (!r && qy == 8 && qx == 0)   check_eq("tpg_y8", {sr, sg, sb}, 24'h000000);
`endif
        if (!r && my == 0) begin
            if (hs && !prev_hs) rise_x = mx;
            if (!hs && prev_hs) fall_x = mx;
            if (de) de_cnt0++;
            if (ln) ln_cnt0++;
        end
        prev_hs = hs;
        if (!r && sfr) begin
            if (last_fr >= 0) begin
                check_eq("frame_period", cyc - last_fr, 325);
                check_eq("vsync_len", s_vcnt, 50);
                check_eq("de_per_frame", s_decnt, 128);
            end
            last_fr = cyc;
            s_vcnt = 0;
            s_decnt = 0;
        end
        if (!r && !svs) s_vcnt++;
        if (!r && sde) s_decnt++;
        rst = next_rst;
    endtask

    initial begin
        repeat (9) tick(1'b1);
        tick(1'b0);
        check_eq("rst_sx", sx, 1055);
        check_eq("rst_sy", sy, 627);
        check_eq("rst_de", de, 0);
        check_eq("rst_hsync", hs, 0);
        check_eq("rst_vsync", vs, 0);
        check_eq("rst_frame", fr, 0);
        check_eq("rst_line", ln, 0);
        check_eq("rst_neg_hsync", shs, 1);
        check_eq("rst_neg_vsync", svs, 1);

        tick(1'b0);
        check_eq("rel_sx", sx, 0);
        check_eq("rel_sy", sy, 0);
        check_eq("rel_de", de, 1);
        check_eq("rel_frame", fr, 1);
        check_eq("rel_line", ln, 1);

        repeat (1055) tick(1'b0);
        check_eq("hsync_rise_x", rise_x, 840);
        check_eq("hsync_fall_x", fall_x, 968);
        check_eq("de_per_line", de_cnt0, 800);
        check_eq("line_pulses", ln_cnt0, 1);
        check_eq("last_sx", sx, 1055);
        tick(1'b0);
        check_eq("wrap_sx", sx, 0);
        check_eq("wrap_sy", sy, 1);

        for (int i = 0; i < 3000 && !(mx == 400 && my == 2); i++) tick(1'b0);
        check_eq("reach_mid", {sx, sy}, {11'd400, 11'd2});
        rst = 1'b1;
        tick(1'b0);
        check_eq("mid_rst_sx", sx, 1055);
        check_eq("mid_rst_hsync", hs, 0);
        tick(1'b0);
        check_eq("restart_sx", sx, 0);
        check_eq("restart_sy", sy, 0);
        check_eq("restart_frame", fr, 1);

        repeat (2200) tick(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/display_timings_600p.md
Name: display_timings_600p

Overview:
- Display timing generator for 800x600 at 60 Hz (VESA), clocked by the 40 MHz pixel clock from the PLL stage.
- Produces screen coordinates, sync pulses, data enable, and frame/line strobes.
- Downstream consumers are the pixel-drawing logic and the 10:1 TMDS/DVI serializer.
- The top level drives rst_pix from the inverse of clk_pix_locked, so timing starts cleanly once the clock is stable.

Parameters:
- CORDW, 11, width of the sx/sy coordinate outputs (unsigned).
- H_RES, 800, active pixels per line.
- H_FP, 40, horizontal front porch (pixels).
- H_SYNC, 128, horizontal sync width (pixels).
- H_BP, 88, horizontal back porch (pixels).
- V_RES, 600, active lines per frame.
- V_FP, 1, vertical front porch (lines).
- V_SYNC, 4, vertical sync width (lines).
- V_BP, 23, vertical back porch (lines).
- H_POL, 1, hsync level while in sync (1 = positive).
- V_POL, 1, vsync level while in sync (1 = positive).

Ports:
- clk_pix  input  1  pixel clock (40 MHz).
- rst_pix  input  1  reset for the pixel-clock domain.
- sx  output  CORDW  current horizontal position, 0..H_TOTAL-1.
- sy  output  CORDW  current vertical position, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- de  output  1  data enable; high in the active area.
- frame  output  1  one-cycle strobe at the start of each frame.
- line  output  1  one-cycle strobe at the start of each line.

Interface rule (already decided): one clock, clk_pix; reset rst_pix is synchronous and active-high.

Behaviour:
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP = 1056.
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP = 628.
- Elaboration check: fail elaboration if H_TOTAL-1 or V_TOTAL-1 does not fit in CORDW bits.
- Counters:
  - sx increments every clk_pix edge and wraps from H_TOTAL-1 to 0.
  - On that wrap, sy increments, wrapping from V_TOTAL-1 to 0.
- All outputs are registered. In any cycle, hsync/vsync/de/frame/line describe the sx/sy values presented in the same cycle (zero skew). Implementation decodes from the next-state counter values.
- de = (sx < H_RES) && (sy < V_RES).
- hsync:
  - Equals H_POL when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC (840..967 at defaults).
  - Equals !H_POL otherwise.
- vsync:
  - Equals V_POL when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC (601..604 at defaults).
  - Equals !V_POL otherwise.
  - Changes only on the edge where sx becomes 0.
- line = 1 when sx == 0. frame = 1 when sx == 0 && sy == 0.
- Reset values, held every cycle rst_pix is high:
  - sx = H_TOTAL-1 (1055), sy = V_TOTAL-1 (627).
  - hsync = !H_POL, vsync = !V_POL.
  - de = 0, frame = 0, line = 0.
- First edge after rst_pix falls: outputs present sx=0, sy=0, de=1, frame=1, line=1.
- Reset asserted mid-frame: takes effect on the next edge; no partial-line cleanup. The next release restarts at (0,0) with a frame strobe.
- No other states. Frame period is exactly H_TOTAL*V_TOTAL = 663168 cycles.

Optional Feature:
- Macro: DISPLAY_TIMINGS_600P_TPG_EN.
- Defined:
  - Adds outputs tpg_r, tpg_g, tpg_b (8 bits each), registered with the same alignment as de.
  - Pattern is 8 vertical colour bars of H_RES/8 pixels, in order white, yellow, cyan, green, magenta, red, blue, black (channels 0xFF or 0x00).
  - Outputs are 0 when de = 0 and during reset.
  - Bar index is computed with a per-line bar counter reloaded on line, not a divider.
- Undefined: the tpg_* ports and logic are absent; the rest of the behaviour is unchanged.

Test Plan:
- Hold rst_pix high 10 cycles:
  - outputs stay sx=1055, sy=627, de=0, hsync=0, vsync=0, frame=0, line=0.
  - Release: the next cycle shows sx=0, sy=0, de=1, frame=1, line=1.
- Run one line:
  - de high for sx 0..799 and low for sx 800..1055.
  - hsync rises at sx=840 and falls at sx=968.
  - line pulses at sx=0 only.
  - sx wraps 1055 -> 0 while sy goes 0 -> 1.
- Run two full frames:
  - frame pulses are exactly 663168 cycles apart.
  - vsync is high for sy 601..604 (4*1056 = 4224 cycles), asserting on the sx=0 edge.
  - de is low for all sy >= 600.
- Assert rst_pix for 1 cycle at sx=400, sy=300: after release, sequence restarts at (0,0) with frame=1. No stray hsync/vsync pulse.
- Rebuild with H_POL=0, V_POL=0: hsync is low only for sx 840..967, vsync low only for sy 601..604, and both are high during reset.
- With DISPLAY_TIMINGS_600P_TPG_EN defined:
  - sx=0 gives FF/FF/FF; sx=100 gives FF/FF/00; sx=799 gives 00/00/00.
  - sx=800 and sy=600 give 0.
